uart_core_cfg: RTL and testbench
================================

// Module: uart_core_cfg
// PURPOSE
//  Runtime-configurable UART core: next-generation UART wrapper. Holds the baud tick generator, TX/RX serialisers and TX/RX FIFOs.
//  Frame format is runtime-selectable: 5-8 data bits, 1/2 stop bits, optional parity.
//  RX entries carry per-byte error flags; a sticky overrun flag records lost frames. Sits behind the bus-side MMIO register slot.
// PARAMETERS
//  DVSR_WIDTH      11  width of baud divisor; tick period = dvsr+1 clk cycles
//  FIFO_ADDR_WIDTH 4   log2 depth of each FIFO (16 entries)
//  OVRSAMPLING     16  ticks per bit; even, >=4
// PORTS
//  clk         in  1           system clock
//  reset       in  1           synchronous, active-low reset
//  dvsr        in  DVSR_WIDTH  baud divisor
//  data_bits   in  2           00=5, 01=6, 10=7, 11=8 data bits
//  stop_2      in  1           1 = two stop bits on TX
//  parity_mode in  2           00/11 none, 01 even, 10 odd
//  wr_uart     in  1           push wr_data into TX FIFO
//  wr_data     in  8           TX byte; bits above data_bits ignored
//  rd_uart     in  1           pop RX FIFO head
//  clr_overrun in  1           clear sticky overrun flag
//  rx          in  1           serial in (pre-synchronised)
//  tx          out 1           serial out
//  rd_data     out 8           RX FIFO head (FWFT); unused high bits = 0
//  rd_err      out 2           head flags {frame_err, parity_err}
//  tx_full, tx_empty, rx_full, rx_empty  out 1 each  FIFO status
//  tx_busy     out 1           serialiser mid-frame
//  overrun     out 1           sticky: RX frame dropped, FIFO full
// BEHAVIOUR
//  Reset (reset==0 at clk edge): tx=1; tx_busy=0; overrun=0; FIFOs flushed (tx_empty=rx_empty=1, full=0).
//   rd_data=0 and rd_err=0 whenever rx_empty=1. Reset mid-frame aborts the frame; tx goes high at that edge.
//  Baud: counter 0..dvsr; tick for one clk when count==dvsr, then wraps to 0. dvsr=0 gives a tick every clk.
//  FIFOs: first-word-fall-through. Write to full is dropped. Read of empty is ignored.
//   Simultaneous rd+wr: both take effect when full; write only when empty. Pointers wrap modulo depth.
//  Status flags update the clk after the push/pop.
//  Config sampling: data_bits/stop_2/parity_mode are latched at frame start (TX: leaving IDLE; RX: start-bit confirm).
//   Changes mid-frame do not affect the current frame.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. Each bit lasts OVRSAMPLING ticks.
//   Leaves IDLE the clk after tx_empty=0; tx_busy=1 from START through STOP. Data is sent LSB first.
//   STOP lasts OVRSAMPLING ticks, or 2*OVRSAMPLING if stop_2. TX FIFO pops on the last STOP tick.
//   With another byte queued, START begins the next clk (no idle gap).
//  RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   IDLE->START on rx==0. Line re-sampled after OVRSAMPLING/2 ticks; rx==1 there is a false start, back to IDLE, no push.
//   Later samples are every OVRSAMPLING ticks at bit centre.
//   STOP samples only the first stop bit: frame_err = (sample==0).
//   parity_err = received parity != computed parity over the latched data_bits.
//   Push {errs,data} at the stop sample, then IDLE. If rx_full, drop the push and set overrun.
//  overrun clears only on clr_overrun. A set and clear in the same clk leaves overrun=1.
// CONFIGURATION
//  UART_PARITY_EN defined: parity_mode honoured; PARITY state inserted on TX and RX.
//   Even: parity bit = XOR of data bits. Odd: its inverse.
//  UART_PARITY_EN undefined: parity_mode ignored, no PARITY state, rd_err[0] tied 0.
// TESTING (dvsr=0, OVRSAMPLING=16 -> 16 clk/bit)
//  8N1, write 0xA5 -> tx low 16 clk, then 1,0,1,0,0,1,0,1 at 16 clk each, then high 16 clk.
//   tx_empty=1 and tx_busy=0 within 1 clk after frame end; total 160 clk.
//  Loopback tx->rx, data_bits=00, write 0xFF -> 5 ones sent; rd_data=0x1F, rd_err=00, rx_empty=0 after stop sample.
//  UART_PARITY_EN, 7 bits, even, write 0x35 -> parity bit 0. Inject parity bit 1 -> rd_err=01, rd_data=0x35.
//  Drive frame with stop bit 0 -> rd_err[1]=1. Then rd_uart -> rx_empty=1, rd_data=0.
//  Receive 17 frames without reading -> rx_full after 16, overrun=1, head still first byte.
//   clr_overrun -> overrun=0.
//  Assert reset mid-DATA with 3 bytes queued -> tx=1 next clk, tx_empty=1, tx_busy=0; no residual frame afterwards.

Source files
------------

// File: rtl/uart_core_cfg_if.sv
// Bus-side bundle of uart_core_cfg: frame configuration, FIFO push/pop and status.
// The master side is the MMIO register slot and the slave side is the UART core.
interface uart_core_cfg_if #(
   parameter int DVSR_WIDTH = 11
);
   logic [DVSR_WIDTH-1:0] dvsr;
   logic [1:0]            data_bits;
   logic                  stop_2;
   logic [1:0]            parity_mode;
   logic                  wr_uart;
   logic [7:0]            wr_data;
   logic                  rd_uart;
   logic                  clr_overrun;
   logic [7:0]            rd_data;
   logic [1:0]            rd_err;
   logic                  tx_full;
   logic                  tx_empty;
   logic                  rx_full;
   logic                  rx_empty;
   logic                  tx_busy;
   logic                  overrun;

   modport master (
      output dvsr, data_bits, stop_2, parity_mode, wr_uart, wr_data, rd_uart, clr_overrun,
      input  rd_data, rd_err, tx_full, tx_empty, rx_full, rx_empty, tx_busy, overrun
   );

   modport slave (
      input  dvsr, data_bits, stop_2, parity_mode, wr_uart, wr_data, rd_uart, clr_overrun,
      output rd_data, rd_err, tx_full, tx_empty, rx_full, rx_empty, tx_busy, overrun
   );
endinterface

// File: rtl/uart_core_cfg.sv
// Runtime-configurable UART: baud tick, TX/RX serialisers and FWFT FIFOs.
// Define UART_PARITY_EN to add the PARITY state and honour parity_mode.
module uart_core_cfg #(
   parameter int DVSR_WIDTH      = 11,
   parameter int FIFO_ADDR_WIDTH = 4,
   parameter int OVRSAMPLING     = 16
) (
   input  logic           clk,
   input  logic           reset,
   uart_core_cfg_if.slave bus,
   input  logic           rx,
   output logic           tx
);
   localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
   localparam int CW    = $clog2(2 * OVRSAMPLING);
   localparam logic [FIFO_ADDR_WIDTH:0] FULL_CNT = (FIFO_ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [FIFO_ADDR_WIDTH:0] ONE_CNT  = (FIFO_ADDR_WIDTH + 1)'(1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(OVRSAMPLING / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST   = CW'(OVRSAMPLING - 1);
   localparam logic [CW-1:0] STOP2_LAST = CW'(2 * OVRSAMPLING - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   function automatic logic [2:0] last_bit(input logic [1:0] code);
      return 3'd4 + {1'b0, code};
   endfunction

   function automatic logic [7:0] data_mask(input logic [1:0] code);
      return 8'hFF >> (3'd3 - {1'b0, code});
   endfunction

`ifdef UART_PARITY_EN
   function automatic logic parity_on(input logic [1:0] mode);
      return (mode == 2'b01) || (mode == 2'b10);
   endfunction
`else
   logic unused_parity_mode;
   assign unused_parity_mode = ^bus.parity_mode;
`endif

   // ---------------- baud tick ----------------
   logic [DVSR_WIDTH-1:0] baud_cnt;
   logic                  tick;

   // Compare with >= so a divisor lowered below the running count still wraps at once.
   assign tick = (baud_cnt >= bus.dvsr);

   always_ff @(posedge clk) begin
      // NOTE: sequential state is written with non-blocking assignments only, so every register samples pre-edge values.
      if (!reset)    baud_cnt <= '0;
      else if (tick) baud_cnt <= '0;
      else           baud_cnt <= baud_cnt + 1'b1;
   end

   // ---------------- TX FIFO ----------------
   logic [7:0]                 tx_mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] tx_wptr, tx_rptr;
   logic [FIFO_ADDR_WIDTH:0]   tx_count;
   logic                       tx_pop, tx_do_rd, tx_do_wr;
   logic [7:0]                 tx_head;

   assign tx_do_rd = tx_pop && (tx_count != '0);
   assign tx_do_wr = bus.wr_uart && ((tx_count != FULL_CNT) || tx_do_rd);
   assign tx_head  = tx_mem[tx_rptr];

   // NOTE: FIFO storage is deliberately left without reset; pointers and count alone define which entries are valid.
   always_ff @(posedge clk) if (tx_do_wr) tx_mem[tx_wptr] <= bus.wr_data;

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_wptr  <= '0;
         tx_rptr  <= '0;
         tx_count <= '0;
      end else begin
         if (tx_do_wr) tx_wptr <= tx_wptr + 1'b1;
         if (tx_do_rd) tx_rptr <= tx_rptr + 1'b1;
         case ({tx_do_wr, tx_do_rd})
            2'b10:   tx_count <= tx_count + 1'b1;
            2'b01:   tx_count <= tx_count - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- RX FIFO: entry = {frame_err, parity_err, data} ----------------
   logic [9:0]                 rx_mem [DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] rx_wptr, rx_rptr;
   logic [FIFO_ADDR_WIDTH:0]   rx_count;
   logic                       rx_push, rx_do_rd, rx_do_wr;
   logic [9:0]                 rx_entry, rx_head;

   assign rx_do_rd = bus.rd_uart && (rx_count != '0);
   assign rx_do_wr = rx_push && ((rx_count != FULL_CNT) || rx_do_rd);
   assign rx_head  = rx_mem[rx_rptr];

   always_ff @(posedge clk) if (rx_do_wr) rx_mem[rx_wptr] <= rx_entry;

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_wptr  <= '0;
         rx_rptr  <= '0;
         rx_count <= '0;
      end else begin
         if (rx_do_wr) rx_wptr <= rx_wptr + 1'b1;
         if (rx_do_rd) rx_rptr <= rx_rptr + 1'b1;
         case ({rx_do_wr, rx_do_rd})
            2'b10:   rx_count <= rx_count + 1'b1;
            2'b01:   rx_count <= rx_count - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- TX serialiser ----------------
   state_t        tx_state, tx_state_n;
   logic [CW-1:0] tx_tcnt, tx_tcnt_n;
   logic [2:0]    tx_bcnt, tx_bcnt_n;
   logic [7:0]    tx_shreg, tx_shreg_n;
   logic [1:0]    tx_bits, tx_bits_n;
   logic          tx_stop2, tx_stop2_n;
   logic          tx_line, tx_line_n;
   logic          tx_load_cfg;
`ifdef UART_PARITY_EN
   logic [1:0]    tx_pmode, tx_pmode_n;
   logic          tx_par, tx_par_n;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_state <= S_IDLE;
         tx_tcnt  <= '0;
         tx_bcnt  <= '0;
         tx_shreg <= '0;
         tx_bits  <= '0;
         tx_stop2 <= 1'b0;
         tx_line  <= 1'b1;
`ifdef UART_PARITY_EN
         tx_pmode <= '0;
         tx_par   <= 1'b0;
`endif
      end else begin
         tx_state <= tx_state_n;
         tx_tcnt  <= tx_tcnt_n;
         tx_bcnt  <= tx_bcnt_n;
         tx_shreg <= tx_shreg_n;
         tx_bits  <= tx_bits_n;
         tx_stop2 <= tx_stop2_n;
         tx_line  <= tx_line_n;
`ifdef UART_PARITY_EN
         tx_pmode <= tx_pmode_n;
         tx_par   <= tx_par_n;
`endif
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path through the case can infer a latch.
      tx_state_n  = tx_state;
      tx_tcnt_n   = tx_tcnt;
      tx_bcnt_n   = tx_bcnt;
      tx_shreg_n  = tx_shreg;
      tx_bits_n   = tx_bits;
      tx_stop2_n  = tx_stop2;
      tx_load_cfg = 1'b0;
      tx_pop      = 1'b0;
`ifdef UART_PARITY_EN
      tx_pmode_n  = tx_pmode;
      tx_par_n    = tx_par;
`endif
      case (tx_state)
         S_IDLE: begin
            if (tx_count != '0) begin
               tx_state_n  = S_START;
               tx_tcnt_n   = '0;
               tx_load_cfg = 1'b1;
            end
         end
         S_START: begin
            if (tick) begin
               if (tx_tcnt == BIT_LAST) begin
                  tx_state_n = S_DATA;
                  tx_tcnt_n  = '0;
                  tx_bcnt_n  = '0;
                  tx_shreg_n = tx_head & data_mask(tx_bits);
`ifdef UART_PARITY_EN
                  tx_par_n   = (^(tx_head & data_mask(tx_bits))) ^ (tx_pmode == 2'b10);
`endif
               end else begin
                  tx_tcnt_n = tx_tcnt + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tx_tcnt == BIT_LAST) begin
                  tx_tcnt_n = '0;
                  if (tx_bcnt == last_bit(tx_bits)) begin
`ifdef UART_PARITY_EN
                     tx_state_n = parity_on(tx_pmode) ? S_PARITY : S_STOP;
`else
                     tx_state_n = S_STOP;
`endif
                  end else begin
                     tx_bcnt_n  = tx_bcnt + 1'b1;
                     tx_shreg_n = tx_shreg >> 1;
                  end
               end else begin
                  tx_tcnt_n = tx_tcnt + 1'b1;
               end
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               if (tx_tcnt == BIT_LAST) begin
                  tx_state_n = S_STOP;
                  tx_tcnt_n  = '0;
               end else begin
                  tx_tcnt_n = tx_tcnt + 1'b1;
               end
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (tx_tcnt == (tx_stop2 ? STOP2_LAST : BIT_LAST)) begin
                  tx_pop    = 1'b1;
                  tx_tcnt_n = '0;
                  // A second queued byte starts straight away, with no idle clk between frames.
                  if (tx_count != ONE_CNT) begin
                     tx_state_n  = S_START;
                     tx_load_cfg = 1'b1;
                  end else begin
                     tx_state_n = S_IDLE;
                  end
               end else begin
                  tx_tcnt_n = tx_tcnt + 1'b1;
               end
            end
         end
         default: tx_state_n = S_IDLE;
      endcase

      if (tx_load_cfg) begin
         tx_bits_n  = bus.data_bits;
         tx_stop2_n = bus.stop_2;
`ifdef UART_PARITY_EN
         tx_pmode_n = bus.parity_mode;
`endif
      end

      // Line level is registered from the next state so tx never glitches.
      case (tx_state_n)
         S_START:  tx_line_n = 1'b0;
         S_DATA:   tx_line_n = tx_shreg_n[0];
`ifdef UART_PARITY_EN
         S_PARITY: tx_line_n = tx_par_n;
`endif
         default:  tx_line_n = 1'b1;
      endcase
   end

   assign tx = tx_line;

   // ---------------- RX deserialiser ----------------
   state_t        rx_state, rx_state_n;
   logic [CW-1:0] rx_tcnt, rx_tcnt_n;
   logic [2:0]    rx_bcnt, rx_bcnt_n;
   logic [7:0]    rx_data, rx_data_n;
   logic [1:0]    rx_bits, rx_bits_n;
   logic          rx_perr_bit;
`ifdef UART_PARITY_EN
   logic [1:0]    rx_pmode, rx_pmode_n;
   logic          rx_perr, rx_perr_n;

   assign rx_perr_bit = rx_perr;
`else
   assign rx_perr_bit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_state <= S_IDLE;
         rx_tcnt  <= '0;
         rx_bcnt  <= '0;
         rx_data  <= '0;
         rx_bits  <= '0;
`ifdef UART_PARITY_EN
         rx_pmode <= '0;
         rx_perr  <= 1'b0;
`endif
      end else begin
         rx_state <= rx_state_n;
         rx_tcnt  <= rx_tcnt_n;
         rx_bcnt  <= rx_bcnt_n;
         rx_data  <= rx_data_n;
         rx_bits  <= rx_bits_n;
`ifdef UART_PARITY_EN
         rx_pmode <= rx_pmode_n;
         rx_perr  <= rx_perr_n;
`endif
      end
   end

   always_comb begin
      rx_state_n = rx_state;
      rx_tcnt_n  = rx_tcnt;
      rx_bcnt_n  = rx_bcnt;
      rx_data_n  = rx_data;
      rx_bits_n  = rx_bits;
      rx_push    = 1'b0;
      rx_entry   = {~rx, rx_perr_bit, rx_data};
`ifdef UART_PARITY_EN
      rx_pmode_n = rx_pmode;
      rx_perr_n  = rx_perr;
`endif
      case (rx_state)
         S_IDLE: begin
            if (!rx) begin
               rx_state_n = S_START;
               rx_tcnt_n  = '0;
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_tcnt == HALF_LAST) begin
                  rx_tcnt_n = '0;
                  if (!rx) begin
                     rx_state_n = S_DATA;
                     rx_bcnt_n  = '0;
                     rx_data_n  = '0;
                     rx_bits_n  = bus.data_bits;
`ifdef UART_PARITY_EN
                     rx_pmode_n = bus.parity_mode;
                     rx_perr_n  = 1'b0;
`endif
                  end else begin
                     rx_state_n = S_IDLE;
                  end
               end else begin
                  rx_tcnt_n = rx_tcnt + 1'b1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (rx_tcnt == BIT_LAST) begin
                  rx_tcnt_n           = '0;
                  rx_data_n[rx_bcnt]  = rx;
                  if (rx_bcnt == last_bit(rx_bits)) begin
`ifdef UART_PARITY_EN
                     rx_state_n = parity_on(rx_pmode) ? S_PARITY : S_STOP;
`else
                     rx_state_n = S_STOP;
`endif
                  end else begin
                     rx_bcnt_n = rx_bcnt + 1'b1;
                  end
               end else begin
                  rx_tcnt_n = rx_tcnt + 1'b1;
               end
            end
         end
`ifdef UART_PARITY_EN
         S_PARITY: begin
            if (tick) begin
               if (rx_tcnt == BIT_LAST) begin
                  rx_state_n = S_STOP;
                  rx_tcnt_n  = '0;
                  rx_perr_n  = rx ^ (^rx_data) ^ (rx_pmode == 2'b10);
               end else begin
                  rx_tcnt_n = rx_tcnt + 1'b1;
               end
            end
         end
`endif
         S_STOP: begin
            if (tick) begin
               if (rx_tcnt == BIT_LAST) begin
                  rx_state_n = S_IDLE;
                  rx_tcnt_n  = '0;
                  rx_push    = 1'b1;
               end else begin
                  rx_tcnt_n = rx_tcnt + 1'b1;
               end
            end
         end
         default: rx_state_n = S_IDLE;
      endcase
   end

   // ---------------- status ----------------
   logic overrun_q;

   // Setting wins over a same-clk clear so a lost frame is never hidden.
   always_ff @(posedge clk) begin
      if (!reset)                     overrun_q <= 1'b0;
      else if (rx_push && !rx_do_wr)  overrun_q <= 1'b1;
      else if (bus.clr_overrun)       overrun_q <= 1'b0;
   end

   assign bus.tx_full  = (tx_count == FULL_CNT);
   assign bus.tx_empty = (tx_count == '0);
   assign bus.rx_full  = (rx_count == FULL_CNT);
   assign bus.rx_empty = (rx_count == '0);
   assign bus.tx_busy  = (tx_state != S_IDLE);
   assign bus.overrun  = overrun_q;
   assign bus.rd_data  = bus.rx_empty ? 8'h00 : rx_head[7:0];
   assign bus.rd_err   = bus.rx_empty ? 2'b00 : rx_head[9:8];
endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg at dvsr=0, 16 clk per bit.
// Expected values are hand-computed; parity expectations follow UART_PARITY_EN.
module tb_uart_core_cfg;
   logic clk = 1'b0;
   logic reset;
   logic rx_drv;
   logic loop;
   logic rx_line;
   logic tx;
   logic [7:0] pat;
   int   n_cmp = 0;
   int   n_err = 0;

`ifdef UART_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   uart_core_cfg_if #(.DVSR_WIDTH(11)) bus ();

   assign rx_line = loop ? tx : rx_drv;

   uart_core_cfg #(
      .DVSR_WIDTH(11),
      .FIFO_ADDR_WIDTH(4),
      .OVRSAMPLING(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .rx(rx_line),
      .tx(tx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input logic [7:0] d);
      bus.wr_uart = 1'b1;
      bus.wr_data = d;
      step(1);
      bus.wr_uart = 1'b0;
   endtask

   task automatic pop_rx();
      bus.rd_uart = 1'b1;
      step(1);
      bus.rd_uart = 1'b0;
   endtask

   task automatic wait_rx(input int budget);
      for (int i = 0; i < budget && bus.rx_empty; i++) step(1);
      check("rx_arrived", bus.rx_empty, 1'b0);
   endtask

   // Drive one frame on rx_drv: start, data LSB first, optional parity (par<0 = none), stop, idle.
   task automatic send_frame(input logic [7:0] d, input int nbits, input int par, input logic stop_v);
      rx_drv = 1'b0;
      step(16);
      for (int i = 0; i < nbits; i++) begin
         rx_drv = d[i];
         step(16);
      end
      if (par >= 0) begin
         rx_drv = par[0];
         step(16);
      end
      rx_drv = stop_v;
      step(16);
      rx_drv = 1'b1;
      step(16);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int lows;
      reset           = 1'b0;
      loop            = 1'b1;
      rx_drv          = 1'b1;
      bus.dvsr        = '0;
      bus.data_bits   = 2'b11;
      bus.stop_2      = 1'b0;
      bus.parity_mode = 2'b00;
      bus.wr_uart     = 1'b0;
      bus.wr_data     = 8'h00;
      bus.rd_uart     = 1'b0;
      bus.clr_overrun = 1'b0;
      step(3);
      check("rst_tx", tx, 1'b1);
      check("rst_busy", bus.tx_busy, 1'b0);
      check("rst_overrun", bus.overrun, 1'b0);
      check("rst_tx_empty", bus.tx_empty, 1'b1);
      check("rst_rx_empty", bus.rx_empty, 1'b1);
      check("rst_tx_full", bus.tx_full, 1'b0);
      check("rst_rx_full", bus.rx_full, 1'b0);
      check("rst_rd_data", bus.rd_data, 8'h00);
      check("rst_rd_err", bus.rd_err, 2'b00);
      reset = 1'b1;
      step(2);

      // 8N1 0xA5 in loopback: exact bit timing on tx, then the echoed byte in the RX FIFO
      pat = 8'hA5;
      push_tx(pat);
      step(9);
      check("a5_start", tx, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(16);
         check($sformatf("a5_bit%0d", i), tx, pat[i]);
      end
      step(16);
      check("a5_stop", tx, 1'b1);
      check("a5_busy_in_stop", bus.tx_busy, 1'b1);
      step(8);
      check("a5_tx_empty", bus.tx_empty, 1'b1);
      check("a5_busy_done", bus.tx_busy, 1'b0);
      check("a5_rx_empty", bus.rx_empty, 1'b0);
      check("a5_rd_data", bus.rd_data, 8'hA5);
      check("a5_rd_err", bus.rd_err, 2'b00);
      pop_rx();
      check("a5_popped_empty", bus.rx_empty, 1'b1);
      check("a5_popped_data", bus.rd_data, 8'h00);

      // 5 data bits: high bits of 0xFF are not sent
      bus.data_bits = 2'b00;
      push_tx(8'hFF);
      wait_rx(200);
      check("d5_rd_data", bus.rd_data, 8'h1F);
      check("d5_rd_err", bus.rd_err, 2'b00);
      pop_rx();
      step(30);
      check("d5_busy_done", bus.tx_busy, 1'b0);

      // 7 bits even parity, 0x35: slot 8 is the parity bit (0) or, without parity, the stop bit
      bus.data_bits   = 2'b10;
      bus.parity_mode = 2'b01;
      push_tx(8'h35);
      step(137);
      check("par_slot8", tx, PAR_EN ? 1'b0 : 1'b1);
      wait_rx(100);
      check("par_rd_data", bus.rd_data, 8'h35);
      check("par_rd_err", bus.rd_err, 2'b00);
      pop_rx();
      step(40);

      // Wrong parity bit injected on the line
      loop = 1'b0;
      send_frame(8'h35, 7, 1, 1'b1);
      check("perr_rd_data", bus.rd_data, 8'h35);
      check("perr_rd_err", bus.rd_err, {1'b0, PAR_EN});
      pop_rx();

      // Stop bit driven low: framing error, no spurious frame from the low stop level
      bus.data_bits   = 2'b11;
      bus.parity_mode = 2'b00;
      send_frame(8'h3C, 8, -1, 1'b0);
      check("ferr_rd_data", bus.rd_data, 8'h3C);
      check("ferr_rd_err", bus.rd_err, 2'b10);
      pop_rx();
      check("ferr_popped_empty", bus.rx_empty, 1'b1);
      check("ferr_popped_data", bus.rd_data, 8'h00);
      check("ferr_popped_err", bus.rd_err, 2'b00);

      // 17 frames with no reads: 16 stored, the 17th dropped and flagged
      for (int k = 1; k <= 17; k++) begin
         send_frame(8'(k), 8, -1, 1'b1);
         if (k == 16) begin
            check("ovr_full_at16", bus.rx_full, 1'b1);
            check("ovr_clear_at16", bus.overrun, 1'b0);
         end
      end
      check("ovr_set", bus.overrun, 1'b1);
      check("ovr_still_full", bus.rx_full, 1'b1);
      check("ovr_head", bus.rd_data, 8'h01);
      bus.clr_overrun = 1'b1;
      step(1);
      bus.clr_overrun = 1'b0;
      check("ovr_cleared", bus.overrun, 1'b0);
      for (int k = 1; k <= 16; k++) begin
         check($sformatf("drain%0d", k), bus.rd_data, 32'(k));
         pop_rx();
      end
      check("drain_empty", bus.rx_empty, 1'b1);

      // Fill the TX FIFO, then reset flushes it
      for (int k = 0; k < 16; k++) push_tx(8'(k));
      check("txf_full", bus.tx_full, 1'b1);
      reset = 1'b0;
      step(1);
      reset = 1'b1;
      check("txf_flushed_full", bus.tx_full, 1'b0);
      check("txf_flushed_empty", bus.tx_empty, 1'b1);

      // Reset mid-DATA with three bytes queued: frame aborted and nothing follows
      push_tx(8'h11);
      push_tx(8'h22);
      push_tx(8'h33);
      step(40);
      check("mid_busy", bus.tx_busy, 1'b1);
      reset = 1'b0;
      step(1);
      check("mid_rst_tx", tx, 1'b1);
      check("mid_rst_empty", bus.tx_empty, 1'b1);
      check("mid_rst_busy", bus.tx_busy, 1'b0);
      reset = 1'b1;
      lows = 0;
      repeat (400) begin
         step(1);
         if (tx !== 1'b1 || bus.tx_busy !== 1'b0) lows++;
      end
      check("mid_no_residual", lows, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
